uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO. Writes go into the FIFO. The FSM pops the head
// into a shift register and sends back-to-back frames with optional parity and 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DATA_W-1:0]            data,
    output logic                         ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic                         tx_busy,
    output logic                         tx_done,
    output logic                         tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(FIFO_DEPTH);
    localparam logic             ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                r_ready;
    logic                r_overflow;

    logic [CLK_W-1:0]    r_clk_cnt;
    logic [3:0]          r_bit_idx;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                r_parity;
    logic                r_tx;
    logic                w_tx_nxt;
    logic                r_tx_done;
    logic                r_busy;

    logic                w_push;
    logic                w_pop;
    logic                w_done;
    logic                w_bit_end;
    logic [DATA_W-1:0]   w_head;

    // ready is registered, so a write while full is refused even if a pop frees a slot this cycle.
    assign w_push    = start & r_ready;
    assign w_bit_end = (r_clk_cnt == CLK_LAST);
    assign w_head    = r_mem[r_rd_ptr];

    // NOTE: every signal written in an always_comb gets a default first; otherwise a missed branch infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && r_bit_idx == DATA_LAST)
                    w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end && r_bit_idx == STOP_LAST) begin
                    w_done = 1'b1;
                    if (r_count != '0) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // tx is registered from the next state, so the line changes on the same edge as the state.
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_pop)
            w_shift_nxt = w_head;
        else if (r_state == S_DATA && w_bit_end)
            w_shift_nxt = r_shift >> 1;

        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            S_PAR:   w_tx_nxt = r_parity;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + CNT_W'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: the storage array has no reset; the reset pointers and count make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != DEPTH);
            if (start && !r_ready) r_overflow <= 1'b1;

            if (r_state == S_IDLE || w_bit_end) r_clk_cnt <= '0;
            else                                r_clk_cnt <= r_clk_cnt + CLK_W'(1);

            if (w_state_nxt != r_state)
                r_bit_idx <= '0;
            else if (w_bit_end && (r_state == S_DATA || r_state == S_STOP))
                r_bit_idx <= r_bit_idx + 4'd1;

            if (w_pop) r_parity <= (^w_head) ^ ODD_PAR;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_tx_done <= w_done;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    assign ready      = r_ready;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign tx_busy    = r_busy;
    assign tx_done    = r_tx_done;
    assign tx         = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover the parity, stop-bit and width variants,
// sharing start/data while idle instances sit in reset.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic [3:0] rst_n;
    logic       start;
    logic [7:0] data_in;

    logic [3:0] rdy_v, ovf_v, busy_v, done_v, tx_v;
    logic [2:0] cnt_v [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // 0: even parity; 1: odd parity; 2: no parity, 2 stop bits; 3: 5-bit data, 2 clocks per bit
    uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_even (
        .clk(clk), .reset(rst_n[0]), .start(start), .data(data_in),
        .ready(rdy_v[0]), .fifo_count(cnt_v[0]), .overflow(ovf_v[0]),
        .tx_busy(busy_v[0]), .tx_done(done_v[0]), .tx(tx_v[0]));

    uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u_odd (
        .clk(clk), .reset(rst_n[1]), .start(start), .data(data_in),
        .ready(rdy_v[1]), .fifo_count(cnt_v[1]), .overflow(ovf_v[1]),
        .tx_busy(busy_v[1]), .tx_done(done_v[1]), .tx(tx_v[1]));

    uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .reset(rst_n[2]), .start(start), .data(data_in),
        .ready(rdy_v[2]), .fifo_count(cnt_v[2]), .overflow(ovf_v[2]),
        .tx_busy(busy_v[2]), .tx_done(done_v[2]), .tx(tx_v[2]));

    uart_tx_fifo #(.DATA_W(5), .CLKS_PER_BIT(2), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_w5 (
        .clk(clk), .reset(rst_n[3]), .start(start), .data(data_in[4:0]),
        .ready(rdy_v[3]), .fifo_count(cnt_v[3]), .overflow(ovf_v[3]),
        .tx_busy(busy_v[3]), .tx_done(done_v[3]), .tx(tx_v[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after the push edge; bits[n] is the n-th bit on the line.
    task automatic run_frame(input int u, input logic [15:0] bits, input int nb, input int cpb,
                             input string tag);
        int bad_tx;
        int bad_ctl;
        bad_tx  = 0;
        bad_ctl = 0;
        for (int i = 0; i < nb * cpb; i++) begin
            tick();
            if (tx_v[u] !== bits[i / cpb]) bad_tx++;
            if (done_v[u] !== 1'b0 || busy_v[u] !== 1'b1) bad_ctl++;
        end
        check({tag, " bit errors"}, bad_tx, 0);
        check({tag, " busy/done during frame"}, bad_ctl, 0);
        tick();
        check({tag, " tx_done at end"}, done_v[u], 1);
        check({tag, " tx_busy at end"}, busy_v[u], 0);
        check({tag, " tx idle"}, tx_v[u], 1);
        tick();
        check({tag, " tx_done one cycle"}, done_v[u], 0);
    endtask

    initial begin
        int bad_tx;
        int bad_done;
        int peak;
        int pos;
        int b;
        int w;
        logic exp_bit;

        rst_n   = 4'b0000;
        start   = 1'b0;
        data_in = 8'h00;
        repeat (3) tick();
        for (int u = 0; u < 4; u++) begin
            check("reset tx", tx_v[u], 1);
            check("reset ready", rdy_v[u], 1);
            check("reset count", cnt_v[u], 0);
            check("reset overflow", ovf_v[u], 0);
            check("reset busy", busy_v[u], 0);
            check("reset done", done_v[u], 0);
        end

        // Even parity, 0xFF: start, eight ones, parity 0, stop.
        rst_n = 4'b0001;
        tick();
        data_in = 8'hFF;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("even push count", cnt_v[0], 1);
        check("even push busy", busy_v[0], 0);
        run_frame(0, 16'h05FE, 11, 4, "even 0xFF");

        // Odd parity, 0xA5: 0,1,0,1,0,0,1,0,1,1,1.
        rst_n = 4'b0010;
        tick();
        data_in = 8'hA5;
        start   = 1'b1;
        tick();
        start = 1'b0;
        run_frame(1, 16'h074A, 11, 4, "odd 0xA5");

        // No parity, two stop bits: start held six cycles, sixth write overflows.
        rst_n = 4'b0100;
        tick();
        data_in = 8'h01;
        start   = 1'b1;
        tick();
        check("burst first push count", cnt_v[2], 1);
        data_in  = 8'h02;
        bad_tx   = 0;
        bad_done = 0;
        peak     = 0;
        for (int c = 0; c < 5 * 44; c++) begin
            tick();
            pos = c % 44;
            b   = pos / 4;
            w   = c / 44 + 1;
            if (b == 0)      exp_bit = 1'b0;
            else if (b <= 8) exp_bit = w[b-1];
            else             exp_bit = 1'b1;
            if (tx_v[2] !== exp_bit) bad_tx++;
            if (done_v[2] !== (c > 0 && pos == 0)) bad_done++;
            if (int'(cnt_v[2]) > peak) peak = int'(cnt_v[2]);
            if (c == 0) check("burst push+pop count", cnt_v[2], 1);
            if (c == 3) begin
                check("burst full count", cnt_v[2], 4);
                check("burst full ready", rdy_v[2], 0);
            end
            if (c == 4) begin
                check("burst overflow", ovf_v[2], 1);
                check("burst dropped count", cnt_v[2], 4);
            end
            if (c <= 3) data_in = 8'(c + 3);
            if (c == 4) start = 1'b0;
        end
        check("burst bit errors", bad_tx, 0);
        check("burst tx_done timing", bad_done, 0);
        check("burst count peak", peak, 4);
        tick();
        check("burst last tx_done", done_v[2], 1);
        check("burst end busy", busy_v[2], 0);
        check("burst end count", cnt_v[2], 0);
        check("burst overflow sticky", ovf_v[2], 1);
        check("burst end ready", rdy_v[2], 1);

        // Reset mid-DATA with two words queued, using the instance whose overflow is set.
        tick();
        start   = 1'b1;
        data_in = 8'h11;
        tick();
        data_in = 8'h22;
        tick();
        data_in = 8'h33;
        tick();
        start = 1'b0;
        check("queued count", cnt_v[2], 2);
        repeat (6) tick();
        check("mid-frame busy", busy_v[2], 1);
        rst_n[2] = 1'b0;
        start    = 1'b1;
        data_in  = 8'h44;
        tick();
        check("mid reset tx", tx_v[2], 1);
        check("mid reset count", cnt_v[2], 0);
        check("mid reset overflow", ovf_v[2], 0);
        check("mid reset busy", busy_v[2], 0);
        check("mid reset done", done_v[2], 0);
        check("mid reset ready", rdy_v[2], 1);
        tick();
        check("start ignored in reset", cnt_v[2], 0);
        start    = 1'b0;
        rst_n[2] = 1'b1;
        bad_tx   = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (tx_v[2] !== 1'b1 || busy_v[2] !== 1'b0) bad_tx++;
        end
        check("no frame after reset", bad_tx, 0);
        data_in = 8'h3C;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("new push starts frame", tx_v[2], 0);

        // 5-bit data, 2 clocks per bit, even parity of 0x1F is 1: 8-bit frame, done 16 cycles after tx falls.
        rst_n = 4'b1000;
        tick();
        data_in = 8'h1F;
        start   = 1'b1;
        tick();
        start = 1'b0;
        run_frame(3, 16'h00FE, 8, 2, "w5 0x1F");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
